// File: rtl/ifu_prefetch_if.sv
// Fetch-side bundle of the instruction prefetch queue: redirect/consumer handshake plus I-Port bus.
// The master modport is the prefetch unit; the slave modport is the core/bus environment around it.
interface ifu_prefetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Consumer handshake: an entry transfers when o_valid & i_ready are both high at a rising
    // clock edge; o_valid and the head fields stay stable until that transfer or a redirect.
    logic                  i_redirect;
    logic [ADDR_WIDTH-1:0] i_pc;
    logic                  i_ready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_instr;
    logic [ADDR_WIDTH-1:0] o_instr_pc;
    logic                  o_err_align;
    logic                  o_err_bus;
    logic [CW-1:0]         o_count;
    logic [ADDR_WIDTH-1:0] o_IAddr;
    logic                  o_IRdC;
    logic [DATA_WIDTH-1:0] i_IData;
    logic                  i_IRdy;
    logic                  i_IErr;

    modport master (
        input  i_redirect, i_pc, i_ready, i_IData, i_IRdy, i_IErr,
        output o_valid, o_instr, o_instr_pc, o_err_align, o_err_bus, o_count, o_IAddr, o_IRdC
    );

    modport slave (
        output i_redirect, i_pc, i_ready, i_IData, i_IRdy, i_IErr,
        input  o_valid, o_instr, o_instr_pc, o_err_align, o_err_bus, o_count, o_IAddr, o_IRdC
    );
endinterface

// File: rtl/ifu_prefetch_queue.sv
// Sequential instruction prefetch queue with redirect flush and in-band fault entries.
// Define IFU_BYPASS_EN to forward a bus response straight to the head when the queue is empty.
module ifu_prefetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter int                    INSTR_SIZE = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    ifu_prefetch_if.master       bus,
    output logic [1:0]           o_dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_IAddr;
    logic                  r_IRdC;

    logic [DATA_WIDTH-1:0] r_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc    [DEPTH];
    logic [DEPTH-1:0]      r_ea;
    logic [DEPTH-1:0]      r_eb;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_resp;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_misaligned;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_instr;
    logic                  w_push_ea;
    logic                  w_push_eb;
    logic                  w_write;
    logic                  w_pop_q;
    logic                  w_valid;

    assign w_resp       = bus.i_IRdy | bus.i_IErr;
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
    assign w_pop_q      = !w_empty && bus.i_ready;

    // Entry produced this cycle; a redirect squashes it along with the rest of the queue.
    always_comb begin
        w_push       = 1'b0;
        w_push_instr = '0;
        w_push_ea    = 1'b0;
        w_push_eb    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_full && w_misaligned) begin
                    w_push    = 1'b1;
                    w_push_ea = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.i_IErr) begin
                    w_push    = 1'b1;
                    w_push_eb = 1'b1;
                end else if (bus.i_IRdy) begin
                    w_push       = 1'b1;
                    w_push_instr = bus.i_IData;
                end
            end
            default: ;
        endcase
        if (bus.i_redirect) begin
            w_push = 1'b0;
        end
    end

`ifdef IFU_BYPASS_EN
    logic w_bypass;
    assign w_bypass = w_empty && (r_state == S_REQ) && bus.i_IRdy && !bus.i_IErr && !bus.i_redirect;
    assign w_write  = w_push && !(w_bypass && bus.i_ready);
`else
    assign w_write  = w_push;
`endif

    always_comb begin
        w_valid        = !w_empty;
        bus.o_instr    = r_instr[r_rd_ptr];
        bus.o_instr_pc = r_pc[r_rd_ptr];
        bus.o_err_align = r_ea[r_rd_ptr];
        bus.o_err_bus  = r_eb[r_rd_ptr];
`ifdef IFU_BYPASS_EN
        if (w_bypass) begin
            w_valid         = 1'b1;
            bus.o_instr     = bus.i_IData;
            bus.o_instr_pc  = r_fetch_pc;
            bus.o_err_align = 1'b0;
            bus.o_err_bus   = 1'b0;
        end
`endif
        bus.o_err_align = bus.o_err_align & w_valid;
        bus.o_err_bus   = bus.o_err_bus & w_valid;
    end

    assign bus.o_valid = w_valid;
    assign bus.o_count = r_count;
    assign bus.o_IAddr = r_IAddr;
    assign bus.o_IRdC  = r_IRdC;
    assign o_dbg_state = r_state;

    // Entry storage needs no reset: the head fields are only meaningful while o_valid is high.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_instr[r_wr_ptr] <= w_push_instr;
            r_pc[r_wr_ptr]    <= r_fetch_pc;
            r_ea[r_wr_ptr]    <= w_push_ea;
            r_eb[r_wr_ptr]    <= w_push_eb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.i_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_q) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_write) - CW'(w_pop_q);
        end
    end

    // Only one read is ever in flight, so a slot reserved at issue time is still free on return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_ADDR;
            r_IAddr    <= '0;
            r_IRdC     <= 1'b0;
        end else if (bus.i_redirect) begin
            r_fetch_pc <= bus.i_pc;
            if ((r_state == S_REQ || r_state == S_DROP) && !w_resp) begin
                r_state <= S_DROP;
            end else begin
                r_state <= S_IDLE;
                r_IRdC  <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_full) begin
                        if (w_misaligned) begin
                            r_state <= S_HALT;
                        end else begin
                            r_IRdC  <= 1'b1;
                            r_IAddr <= r_fetch_pc;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.i_IErr) begin
                        r_IRdC  <= 1'b0;
                        r_state <= S_HALT;
                    end else if (bus.i_IRdy) begin
                        r_IRdC     <= 1'b0;
                        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INSTR_SIZE);
                        r_state    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (w_resp) begin
                        r_IRdC  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Scoreboard bench for ifu_prefetch_queue: directed fetch/redirect/fault scenarios, then random traffic.
module tb_ifu_prefetch_queue;
    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RST_ADDR = 32'h100;
    localparam int          EW       = 2 + AW + DW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    ifu_prefetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    ifu_prefetch_queue #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .INSTR_SIZE(4), .RESET_ADDR(RST_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Reference model: program order of expected entries plus the architectural fetch pointer.
    logic [EW-1:0] exp_q[$];
    logic [31:0]   req_log[$];
    logic [31:0]   m_pc;
    logic [31:0]   m_req_addr;
    bit            m_out, m_squash, m_halt;
    int            req_cnt;
    int            max_count;
    bit            mon_en;

    // Bus responder controls
    int          resp_mode;
    bit          hold_en, err_en;
    logic [31:0] hold_addr, err_addr;
    int          err_pct;

    task automatic tick();
        bit go;
        @(posedge clk);
        #1;
        bus.i_redirect = 1'b0;
        bus.i_IRdy     = 1'b0;
        bus.i_IErr     = 1'b0;
        bus.i_IData    = '0;
        if (bus.o_IRdC && !(hold_en && bus.o_IAddr == hold_addr)) begin
            go = (resp_mode == 1) || ($urandom_range(0, 2) == 0);
            if (go) begin
                if ((err_en && bus.o_IAddr == err_addr) || ($urandom_range(0, 99) < err_pct)) begin
                    bus.i_IErr = 1'b1;
                end else begin
                    bus.i_IRdy  = 1'b1;
                    bus.i_IData = mem_word(bus.o_IAddr);
                end
            end
        end
    endtask

    task automatic redirect(input logic [31:0] a);
        bus.i_redirect = 1'b1;
        bus.i_pc       = a;
    endtask

    task automatic wait_new_req(input int max_cycles, output bit ok);
        int base;
        base = req_cnt;
        for (int k = 0; k < max_cycles && req_cnt == base; k++) tick();
        ok = (req_cnt != base);
    endtask

    // Monitor: compares every consumed head entry and the bus behaviour against the model.
    logic [EW-1:0] mon_head, mon_act;
    int            mon_sz0;
    bit            mon_out0;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_sz0  = exp_q.size();
            mon_out0 = m_out;
            check("count", EW'(bus.o_count), EW'(mon_sz0));
            check("valid", EW'(bus.o_valid), EW'(mon_sz0 != 0));
            if (int'(bus.o_count) > max_count) max_count = int'(bus.o_count);

            if (bus.o_valid && bus.i_ready && !bus.i_redirect) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", EW'(bus.o_valid), EW'(0));
                end else begin
                    mon_head = exp_q.pop_front();
                    mon_act  = {bus.o_err_bus, bus.o_err_align, bus.o_instr_pc,
                                mon_head[AW+DW] ? 32'h0 : bus.o_instr};
                    check("pop_entry", mon_act, mon_head);
                end
            end

            if (m_out) begin
                check("rdc_held", EW'(bus.o_IRdC), EW'(1));
                check("req_stable", EW'(bus.o_IAddr), EW'(m_req_addr));
            end else if (bus.o_IRdC) begin
                m_out      = 1'b1;
                m_req_addr = bus.o_IAddr;
                req_cnt++;
                req_log.push_back(bus.o_IAddr);
                check("req_addr", EW'(bus.o_IAddr), EW'(m_pc));
                check("req_not_halted", EW'(m_halt), EW'(0));
            end

            if (m_out && (bus.i_IRdy || bus.i_IErr)) begin
                m_out = 1'b0;
                if (m_squash || bus.i_redirect) begin
                    m_squash = 1'b0;
                end else if (bus.i_IErr) begin
                    exp_q.push_back({1'b1, 1'b0, m_pc, 32'h0});
                    m_halt = 1'b1;
                end else begin
                    exp_q.push_back({2'b00, m_pc, mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end else if (!mon_out0 && !m_halt && m_pc[1:0] != 2'b00 && !bus.i_redirect && mon_sz0 < DEPTH) begin
                exp_q.push_back({1'b0, 1'b1, m_pc, 32'h0});
                m_halt = 1'b1;
            end

            if (bus.i_redirect) begin
                exp_q.delete();
                m_pc   = bus.i_pc;
                m_halt = 1'b0;
                if (m_out) m_squash = 1'b1;
            end
        end
    end

    initial begin
        bit          ok;
        int          base;
        logic [31:0] a;
        bus.i_redirect = 1'b0;
        bus.i_pc       = '0;
        bus.i_ready    = 1'b0;
        bus.i_IData    = '0;
        bus.i_IRdy     = 1'b0;
        bus.i_IErr     = 1'b0;
        resp_mode = 1; hold_en = 0; err_en = 0; err_pct = 0;
        hold_addr = '0; err_addr = '0;
        m_pc = RST_ADDR; m_out = 0; m_squash = 0; m_halt = 0; m_req_addr = '0;
        req_cnt = 0; max_count = 0; mon_en = 0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", EW'(bus.o_valid), EW'(0));
        check("rst_count", EW'(bus.o_count), EW'(0));
        check("rst_rdc", EW'(bus.o_IRdC), EW'(0));
        check("rst_iaddr", EW'(bus.o_IAddr), EW'(0));
        check("rst_errs", EW'({bus.o_err_align, bus.o_err_bus}), EW'(0));
        rst    = 1'b0;
        mon_en = 1'b1;

        // Sequential fetch from the reset address with an always-ready consumer
        bus.i_ready = 1'b1;
        repeat (15) tick();
        check("seq_nreq", EW'(req_log.size() >= 3), EW'(1));
        if (req_log.size() >= 3) begin
            check("seq_addr0", EW'(req_log[0]), EW'(32'h100));
            check("seq_addr1", EW'(req_log[1]), EW'(32'h104));
            check("seq_addr2", EW'(req_log[2]), EW'(32'h108));
        end
        check("seq_max_count", EW'(max_count <= 1), EW'(1));

        // Stalled consumer: exactly DEPTH reads fill the queue
        tick();
        bus.i_ready = 1'b0;
        redirect(32'h400);
        tick();
        base = req_cnt;
        repeat (40) tick();
        check("fill_reads", EW'(req_cnt - base), EW'(DEPTH));
        check("fill_count", EW'(bus.o_count), EW'(DEPTH));
        check("fill_rdc", EW'(bus.o_IRdC), EW'(0));
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        wait_new_req(10, ok);
        check("refill_after_pop", EW'(ok), EW'(1));

        // Redirect while a read is pending: request held, response dropped, queue empty
        bus.i_ready = 1'b1;
        hold_en = 1; hold_addr = 32'h10C;
        tick();
        redirect(32'h100);
        for (int k = 0; k < 60 && !(bus.o_IRdC && bus.o_IAddr == 32'h10C); k++) tick();
        check("drop_reach_10c", EW'(bus.o_IRdC && bus.o_IAddr == 32'h10C), EW'(1));
        tick();
        tick();
        redirect(32'h200);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("drop_rdc_held", EW'(bus.o_IRdC), EW'(1));
            check("drop_addr_held", EW'(bus.o_IAddr), EW'(32'h10C));
            check("drop_empty", EW'(bus.o_count), EW'(0));
        end
        hold_en = 0;
        wait_new_req(10, ok);
        check("drop_next_req", EW'(ok), EW'(1));
        check("drop_next_addr", EW'(req_log[$]), EW'(32'h200));

        // Misaligned redirect: fault entry without a bus read, then halt
        tick();
        bus.i_ready = 1'b0;
        redirect(32'h202);
        repeat (4) tick();
        check("align_valid", EW'(bus.o_valid), EW'(1));
        check("align_flag", EW'({bus.o_err_align, bus.o_err_bus}), EW'(2'b10));
        check("align_pc", EW'(bus.o_instr_pc), EW'(32'h202));
        base = req_cnt;
        repeat (10) tick();
        check("align_halt_reads", EW'(req_cnt - base), EW'(0));
        check("align_halt_rdc", EW'(bus.o_IRdC), EW'(0));
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;

        // Bus error: fault entry with zero instruction, then halt
        err_en = 1; err_addr = 32'h300;
        redirect(32'h300);
        repeat (6) tick();
        check("berr_valid", EW'(bus.o_valid), EW'(1));
        check("berr_flag", EW'({bus.o_err_align, bus.o_err_bus}), EW'(2'b01));
        check("berr_pc", EW'(bus.o_instr_pc), EW'(32'h300));
        check("berr_instr", EW'(bus.o_instr), EW'(0));
        base = req_cnt;
        repeat (10) tick();
        check("berr_halt_reads", EW'(req_cnt - base), EW'(0));
        check("berr_halt_rdc", EW'(bus.o_IRdC), EW'(0));
        err_en = 0;

        // Full queue with pop and redirect in the same cycle
        redirect(32'h500);
        repeat (30) tick();
        check("full_count", EW'(bus.o_count), EW'(DEPTH));
        bus.i_ready = 1'b1;
        redirect(32'h600);
        tick();
        bus.i_ready = 1'b0;
        check("full_redir_count", EW'(bus.o_count), EW'(0));
        check("full_redir_valid", EW'(bus.o_valid), EW'(0));
        wait_new_req(10, ok);
        check("full_redir_req", EW'(ok), EW'(1));
        check("full_redir_addr", EW'(req_log[$]), EW'(32'h600));

        // Random traffic: latency, backpressure, redirects, faults, PC wrap
        resp_mode = 0;
        err_pct   = 2;
        for (int c = 0; c < 3000; c++) begin
            tick();
            bus.i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 9))
                    0:       a = 32'hFFFF_FFF8;
                    1:       a = ($urandom & 32'h0000_FFFC) | 32'h2;
                    default: a = $urandom & 32'h0000_FFFC;
                endcase
                redirect(a);
            end
        end
        err_pct     = 0;
        bus.i_ready = 1'b1;
        repeat (20) tick();
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
